// File: rtl/arb_pkg.sv
// Shared constants and helpers for the arbitrating multiplexer.
package arb_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (x != 0) begin
        r = r + 1;
        x = x >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Combinational grant picker: round-robin from ptr, or fixed priority from 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int CH_W  = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              mode,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_any
);

  logic [CH_W-1:0]     base;
  logic [2*NUM_CH-1:0] dbl;
  logic                found;

  // The lower copy is masked below the start point; the upper copy supplies
  // the wrapped-around candidates, so the first set bit is the circular winner.
  always_comb begin
    base    = (mode == MODE_FIXED) ? '0 : ptr;
    dbl     = {req, req} & ({(2*NUM_CH){1'b1}} << base);
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < 2 * NUM_CH; i++) begin
      if (!found && dbl[i]) begin
        found   = 1'b1;
        gnt_idx = CH_W'(i % NUM_CH);
      end
    end
    gnt_any = |req;
  end

endmodule

// File: rtl/arb_mux.sv
// N:1 valid/ready multiplexer with round-robin or fixed-priority arbitration
// and a single registered output stage.
module arb_mux
  import arb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  localparam int CH_W  = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prio_mode,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch
);

  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic             free;
  logic             take;
  logic [WIDTH-1:0] sel_data;

  rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .mode    (prio_mode),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Accept decode and selected-channel data.
  always_comb begin
    free     = !out_valid || out_ready;
    take     = free && gnt_any;
    in_ready = '0;
    if (take && !rst) in_ready = NUM_CH'(1) << gnt_idx;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == CH_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register: load on grant, drain on downstream accept, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_ch    <= gnt_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer advances past the winner only in round-robin mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (take && prio_mode == MODE_RR) begin
      rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed self-checking bench for arb_mux (4-channel and 1-channel builds).
module tb_arb_mux;

  logic         clk = 1'b0;
  logic         rst;
  logic         prio_mode;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_ch;

  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_out_valid;
  logic         s_out_ready;
  logic [31:0]  s_out_data;
  logic         s_out_ch;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(32), .NUM_CH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .prio_mode (prio_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  arb_mux #(.WIDTH(32), .NUM_CH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .prio_mode (prio_mode),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .in_data   (s_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .out_ch    (s_out_ch)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sent;
    int recv;
    logic [2:0] rpat;

    rst = 1'b1; prio_mode = 1'b0; in_valid = '0; out_ready = 1'b0;
    set_data(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    s_valid = 1'b0; s_data = '0; s_out_ready = 1'b0;
    step();
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 4'b0000);

    // 1. asynchronous reset while a beat is held
    rst = 1'b0;
    in_valid = 4'b0001;
    step();
    in_valid = 4'b0000;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_data", out_data, 32'hA0);
    #3 rst = 1'b1;
    #1;
    check("async_valid", out_valid, 0);
    check("async_data", out_data, 0);
    check("async_ch", out_ch, 0);
    in_valid = 4'b1111;
    #1;
    check("rst_inready_zero", in_ready, 4'b0000);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("first_grant", in_ready, 4'b0001);

    // 2. round-robin fairness, one beat per cycle
    for (int k = 0; k < 6; k++) begin
      check("rr_inready", in_ready, 4'b0001 << (k % 4));
      step();
      check("rr_valid", out_valid, 1);
      check("rr_ch", out_ch, k % 4);
      check("rr_data", out_data, 32'hA0 + (k % 4));
    end

    // 3. pointer wrap and skip (pointer is now 2; one more grant brings it to 3)
    check("pre_wrap", in_ready, 4'b0100);
    step();
    check("wrap_ch2", out_ch, 2);
    in_valid = 4'b1010;
    #1;
    check("skip_to3", in_ready, 4'b1000);
    step();
    check("wrap_ch3", out_ch, 3);
    check("wrap_d3", out_data, 32'hA3);
    check("skip_to1", in_ready, 4'b0010);
    step();
    check("wrap_ch1", out_ch, 1);
    in_valid = 4'b1111;
    #1;
    check("ptr_is2", in_ready, 4'b0100);

    // 4. fixed priority starves channel 2; pointer stays frozen
    prio_mode = 1'b1;
    in_valid = 4'b0110;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("fix_inready", in_ready, 4'b0010);
      step();
      check("fix_ch", out_ch, 1);
      check("fix_data", out_data, 32'hA1);
    end
    prio_mode = 1'b0;
    in_valid = 4'b1111;
    #1;
    check("resume_rr", in_ready, 4'b0100);
    step();
    check("resume_ch", out_ch, 2);

    // 5. backpressure with a held 0xDEADBEEF beat from channel 2 (pointer is 3)
    set_data(32'hA0, 32'hA1, 32'hDEADBEEF, 32'hA3);
    in_valid = 4'b0100;
    #1;
    check("bp_grant", in_ready, 4'b0100);
    step();
    check("bp_load_data", out_data, 32'hDEADBEEF);
    check("bp_load_ch", out_ch, 2);
    in_valid = 4'b0001;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_inready", in_ready, 4'b0000);
      step();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 32'hDEADBEEF);
      check("bp_ch", out_ch, 2);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", in_ready, 4'b0001);
    step();
    check("bp_next_valid", out_valid, 1);
    check("bp_next_ch", out_ch, 0);
    check("bp_next_data", out_data, 32'hA0);
    in_valid = 4'b0000;
    step();
    check("drain_valid", out_valid, 0);
    check("drain_hold", out_data, 32'hA0);

    // 6. single-channel build: five beats, out_ready cycling 1,0,1
    sent = 0;
    recv = 0;
    rpat = 3'b101;
    for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
      s_valid = (sent < 5);
      s_data = 32'hB0 + sent;
      s_out_ready = rpat[cyc % 3];
      #1;
      if (s_out_valid && s_out_ready) begin
        check("one_data", s_out_data, 32'hB0 + recv);
        check("one_ch", s_out_ch, 0);
        recv++;
      end
      if (s_valid && s_ready) sent++;
      step();
    end
    check("one_recv", recv, 5);
    check("one_sent", sent, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised N:1 data multiplexer. Successor to the 2:1 select mux used in the datapath.
- Adds per-channel valid/ready handshake, round-robin or fixed-priority arbitration, and one registered output stage.
- Use it where several requesters share one downstream port, e.g. instruction fetch and load/store sharing a single memory port in the multi-cycle core.

Parameters:
- WIDTH, 32, data width per channel in bits.
- NUM_CH, 4, number of input channels; legal range is 1 and up.
- CH_W, max(1, clog2(NUM_CH)), width of the channel index. Derived; never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- prio_mode  input  1  0 = round-robin, 1 = fixed priority with channel 0 highest.
- in_valid  input  NUM_CH  per-channel request.
- in_ready  output  NUM_CH  per-channel accept; one-hot or zero.
- in_data  input  NUM_CH*WIDTH  flat bus; channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  registered data.
- out_ch  output  CH_W  index of the channel that supplied out_data.

Behaviour:
- Reset state (asynchronous, immediate): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is 0 while rst is high.
- free = !out_valid || out_ready. The output register can load this cycle.
- Grant selection (combinational):
  - Round-robin mode: g is the first index with in_valid set, scanning circularly from rr_ptr upward through NUM_CH-1, then wrapping to 0.
  - Fixed-priority mode: g is the lowest index with in_valid set. rr_ptr is ignored.
- in_ready[g] = free && (any in_valid). All other in_ready bits are 0.
- in_ready may depend combinationally on in_valid and out_ready. Requesters must not make in_valid depend on in_ready.
- Transfer on input channel i: in_valid[i] && in_ready[i] at a clock edge. At that edge:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
- Pointer update: in round-robin mode only, rr_ptr <= (g+1) mod NUM_CH on each transfer. Wrap from NUM_CH-1 to 0.
- Output transfer: out_valid && out_ready. If no input transfers on the same edge, out_valid <= 0. out_data and out_ch hold their values.
- Simultaneous output transfer and new grant: the register reloads with the new beat. This gives full throughput of 1 beat per cycle with no bubble.
- Stall (out_valid=1, out_ready=0):
  - out_data and out_ch are held stable.
  - All in_ready bits are 0.
  - rr_ptr is frozen.
- Latency is one cycle from input transfer to out_valid.
- Requesters must hold in_valid and in_data until accepted. The arbiter does not check this.
- Mode change mid-stream: takes effect on the next grant. rr_ptr keeps its value and resumes when round-robin mode is re-selected.
- NUM_CH=1: g is always 0 and CH_W=1. out_ch is always 0 and rr_ptr stays 0. The block degenerates to a single register slice with handshake.
- Reset asserted mid-stream: any held beat is dropped. Resume from the reset state above.

Decomposition:
- Shared package arb_pkg holds:
  - the mode constants MODE_RR=1'b0 and MODE_FIXED=1'b1;
  - a clog2 helper function used to derive CH_W.
- One sub-module, rr_pick: purely combinational.
  - Inputs: req[NUM_CH], ptr[CH_W], mode.
  - Outputs: gnt_idx[CH_W], gnt_any.
  - Implementation: double-width request vector with masking.
- arb_mux instantiates rr_pick and owns:
  - the rr_ptr register;
  - the output register;
  - the in_ready decode.

Test Plan (NUM_CH=4, WIDTH=32 unless stated):
1. Reset check: assert rst asynchronously mid-cycle while out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately. After release, the first grant with all four requesting is channel 0.
2. Round-robin fairness: all four in_valid held high, out_ready=1, data 0xA0..0xA3 per channel -> one beat per cycle. out_ch sequence is 0,1,2,3,0,1 with out_data matching each channel. No idle cycle.
3. Pointer wrap and skip: rr_ptr=3, only channels 1 and 3 requesting -> channel 3 granted, then channel 1. rr_ptr becomes 0, then 2.
4. Fixed-priority mode: prio_mode=1, channels 1 and 2 requesting continuously -> channel 1 granted every cycle and channel 2 starves. After switching to prio_mode=0, the next grant follows the frozen rr_ptr.
5. Backpressure: out_ready=0 for 3 cycles with a beat of 0xDEADBEEF from channel 2 held -> out_data and out_ch stable, in_ready=0000. On out_ready=1, the held beat transfers and the next grant loads on the same edge.
6. Degenerate NUM_CH=1: single requester sends 5 beats with out_ready toggling 1,0,1 -> beats arrive in order, none lost or duplicated, out_ch always 0.
